ycr1_wb_sram_slv: RTL and testbench

//  Wishbone slave responder that terminates the data-side Wishbone bus from the core bridge.

---
 rtl/ycr1_wb_sram_slv.sv | 185 ++++++++++++++++++
 tb/tb_ycr1_wb_sram_slv.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_wb_sram_slv.sv
// Wishbone data-side slave that turns each transfer into one access on a 1RW SRAM macro.
// Optional define YCR1_WB_SRAM_RDREG_EN adds a register stage on the SRAM read data path.
module ycr1_wb_sram_slv #(
   parameter int          SRAM_AW   = 9,
   parameter logic [31:0] BASE_ADDR = 32'h0C00_0000
) (
   input  logic               wb_clk,
   input  logic               wb_rst,
   input  logic               wbd_stb_i,
   input  logic [31:0]        wbd_adr_i,
   input  logic               wbd_we_i,
   input  logic [31:0]        wbd_dat_i,
   input  logic [3:0]         wbd_sel_i,
   output logic [31:0]        wbd_dat_o,
   output logic               wbd_ack_o,
   output logic               wbd_err_o,
   output logic               sram_csb_o,
   output logic               sram_web_o,
   output logic [3:0]         sram_wmask_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_din_o,
   input  logic [31:0]        sram_dout_i
);

   localparam logic [31:0] WIN_MASK = ~((32'd1 << (SRAM_AW + 2)) - 32'd1);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
`ifdef YCR1_WB_SRAM_RDREG_EN
      RDW,
`endif
      ACK
   } state_t;

   state_t             r_state,   w_state;
   logic               r_rd_phase, w_rd_phase;
   logic               r_ack,     w_ack;
   logic               r_err,     w_err;
   logic [31:0]        r_dat,     w_dat;
   logic               r_csb,     w_csb;
   logic               r_web,     w_web;
   logic [3:0]         r_wmask,   w_wmask;
   logic [SRAM_AW-1:0] r_addr,    w_addr;
   logic [31:0]        r_din,     w_din;
`ifdef YCR1_WB_SRAM_RDREG_EN
   logic [31:0]        r_rd_buf,  w_rd_buf;
`endif
   logic               w_hit;

   assign w_hit = ((wbd_adr_i & WIN_MASK) == BASE_ADDR);

   always_comb begin
      w_state    = r_state;
      w_rd_phase = r_rd_phase;
      w_ack      = r_ack;
      w_err      = r_err;
      w_dat      = r_dat;
      w_csb      = r_csb;
      w_web      = r_web;
      w_wmask    = r_wmask;
      w_addr     = r_addr;
      w_din      = r_din;
`ifdef YCR1_WB_SRAM_RDREG_EN
      w_rd_buf   = r_rd_buf;
`endif
      case (r_state)
         IDLE: begin
            if (wbd_stb_i) begin
               if (w_hit) begin
                  w_csb  = 1'b0;
                  w_addr = wbd_adr_i[SRAM_AW+1:2];
                  if (wbd_we_i) begin
                     w_web   = 1'b0;
                     w_wmask = wbd_sel_i;
                     w_din   = wbd_dat_i;
                     w_state = WR;
                  end else begin
                     w_web      = 1'b1;
                     w_wmask    = 4'h0;
                     w_rd_phase = 1'b0;
                     w_state    = RD;
                  end
               end else begin
                  w_ack   = 1'b1;
                  w_err   = 1'b1;
                  w_dat   = 32'h0;
                  w_state = ACK;
               end
            end
         end
         WR: begin
            w_csb   = 1'b1;
            w_web   = 1'b1;
            w_ack   = 1'b1;
            w_err   = 1'b0;
            w_state = ACK;
         end
         RD: begin
            // first cycle lets the macro sample csb; dout is valid in the second
            w_csb = 1'b1;
            w_web = 1'b1;
            if (!r_rd_phase) begin
               w_rd_phase = 1'b1;
            end else begin
               w_rd_phase = 1'b0;
`ifdef YCR1_WB_SRAM_RDREG_EN
               w_rd_buf   = sram_dout_i;
               w_state    = RDW;
`else
               w_dat      = sram_dout_i;
               w_ack      = 1'b1;
               w_err      = 1'b0;
               w_state    = ACK;
`endif
            end
         end
`ifdef YCR1_WB_SRAM_RDREG_EN
         RDW: begin
            w_dat   = r_rd_buf;
            w_ack   = 1'b1;
            w_err   = 1'b0;
            w_state = ACK;
         end
`endif
         ACK: begin
            w_ack   = 1'b0;
            w_err   = 1'b0;
            w_dat   = 32'h0;
            w_state = IDLE;
         end
         default: begin
            w_ack   = 1'b0;
            w_err   = 1'b0;
            w_dat   = 32'h0;
            w_csb   = 1'b1;
            w_web   = 1'b1;
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state    <= IDLE;
         r_rd_phase <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_dat      <= 32'h0;
         r_csb      <= 1'b1;
         r_web      <= 1'b1;
         r_wmask    <= 4'h0;
         r_addr     <= '0;
         r_din      <= 32'h0;
`ifdef YCR1_WB_SRAM_RDREG_EN
         r_rd_buf   <= 32'h0;
`endif
      end else begin
         r_state    <= w_state;
         r_rd_phase <= w_rd_phase;
         r_ack      <= w_ack;
         r_err      <= w_err;
         r_dat      <= w_dat;
         r_csb      <= w_csb;
         r_web      <= w_web;
         r_wmask    <= w_wmask;
         r_addr     <= w_addr;
         r_din      <= w_din;
`ifdef YCR1_WB_SRAM_RDREG_EN
         r_rd_buf   <= w_rd_buf;
`endif
      end
   end

   assign wbd_dat_o    = r_dat;
   assign wbd_ack_o    = r_ack;
   assign wbd_err_o    = r_err;
   assign sram_csb_o   = r_csb;
   assign sram_web_o   = r_web;
   assign sram_wmask_o = r_wmask;
   assign sram_addr_o  = r_addr;
   assign sram_din_o   = r_din;

endmodule

// File: tb/tb_ycr1_wb_sram_slv.sv
// Directed bench for ycr1_wb_sram_slv with a behavioural 1RW SRAM model.
module tb_ycr1_wb_sram_slv;

`ifdef YCR1_WB_SRAM_RDREG_EN
   localparam int RD_LAT = 4;
`else
   localparam int RD_LAT = 3;
`endif

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic        wbd_stb_i;
   logic [31:0] wbd_adr_i;
   logic        wbd_we_i;
   logic [31:0] wbd_dat_i;
   logic [3:0]  wbd_sel_i;
   logic [31:0] wbd_dat_o;
   logic        wbd_ack_o;
   logic        wbd_err_o;
   logic        sram_csb_o;
   logic        sram_web_o;
   logic [3:0]  sram_wmask_o;
   logic [8:0]  sram_addr_o;
   logic [31:0] sram_din_o;
   logic [31:0] sram_dout_i = 32'h0;

   logic [31:0] mem [0:511];
   int          n_checks = 0;
   int          n_err    = 0;
   int          ack_cnt  = 0;
   int          csb_lo   = 0;

   always #5 wb_clk = ~wb_clk;

   ycr1_wb_sram_slv #(.SRAM_AW(9), .BASE_ADDR(32'h0C00_0000)) dut (
      .wb_clk       (wb_clk),
      .wb_rst       (wb_rst),
      .wbd_stb_i    (wbd_stb_i),
      .wbd_adr_i    (wbd_adr_i),
      .wbd_we_i     (wbd_we_i),
      .wbd_dat_i    (wbd_dat_i),
      .wbd_sel_i    (wbd_sel_i),
      .wbd_dat_o    (wbd_dat_o),
      .wbd_ack_o    (wbd_ack_o),
      .wbd_err_o    (wbd_err_o),
      .sram_csb_o   (sram_csb_o),
      .sram_web_o   (sram_web_o),
      .sram_wmask_o (sram_wmask_o),
      .sram_addr_o  (sram_addr_o),
      .sram_din_o   (sram_din_o),
      .sram_dout_i  (sram_dout_i)
   );

   // 1RW macro: write under mask, or registered read data valid after the edge
   always @(posedge wb_clk) begin
      if (sram_csb_o === 1'b0) begin
         if (sram_web_o === 1'b0) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
         end else begin
            sram_dout_i <= mem[sram_addr_o];
         end
      end
   end

   always @(negedge wb_clk) begin
      if (wbd_ack_o === 1'b1) ack_cnt <= ack_cnt + 1;
      if (sram_csb_o === 1'b0) csb_lo <= csb_lo + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   // Called at posedge+1 (cycle 0); returns in the ack cycle, lat = cycles from cycle 0.
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input logic keep,
                       output int lat, output logic err, output logic [31:0] rdat);
      wbd_adr_i = adr;
      wbd_we_i  = we;
      wbd_dat_i = dat;
      wbd_sel_i = sel;
      wbd_stb_i = 1'b1;
      lat  = 0;
      err  = 1'b0;
      rdat = 32'h0;
      while (lat < 10) begin
         step();
         lat++;
         if (wbd_ack_o === 1'b1) break;
      end
      if (wbd_ack_o !== 1'b1) lat = 99;
      err  = wbd_err_o;
      rdat = wbd_dat_o;
      if (!keep) wbd_stb_i = 1'b0;
   endtask

   task automatic post(input string tag);
      step();
      chk({tag, "_ack_clr"}, 32'(wbd_ack_o), 32'h0);
      chk({tag, "_dat_clr"}, wbd_dat_o, 32'h0);
   endtask

   initial begin
      int          lat;
      logic        err;
      logic [31:0] rd;
      int          acks0;
      int          csb0;

      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      wb_rst = 1'b1; wbd_stb_i = 1'b0; wbd_adr_i = 32'h0; wbd_we_i = 1'b0;
      wbd_dat_i = 32'h0; wbd_sel_i = 4'h0;
      #1;
      chk("rst_ack",   32'(wbd_ack_o), 32'h0);
      chk("rst_err",   32'(wbd_err_o), 32'h0);
      chk("rst_dat",   wbd_dat_o, 32'h0);
      chk("rst_csb",   32'(sram_csb_o), 32'h1);
      chk("rst_web",   32'(sram_web_o), 32'h1);
      chk("rst_wmask", 32'(sram_wmask_o), 32'h0);
      chk("rst_addr",  32'(sram_addr_o), 32'h0);
      chk("rst_din",   sram_din_o, 32'h0);
      repeat (2) @(posedge wb_clk);
      #1 wb_rst = 1'b0;
      step();

      // full-word write with per-cycle checks
      wbd_adr_i = 32'h0C00_0010; wbd_we_i = 1'b1; wbd_dat_i = 32'hDEAD_BEEF;
      wbd_sel_i = 4'hF; wbd_stb_i = 1'b1;
      step();
      chk("wr_c1_csb",   32'(sram_csb_o), 32'h0);
      chk("wr_c1_web",   32'(sram_web_o), 32'h0);
      chk("wr_c1_addr",  32'(sram_addr_o), 32'h4);
      chk("wr_c1_wmask", 32'(sram_wmask_o), 32'hF);
      chk("wr_c1_din",   sram_din_o, 32'hDEAD_BEEF);
      chk("wr_c1_ack",   32'(wbd_ack_o), 32'h0);
      step();
      chk("wr_c2_ack", 32'(wbd_ack_o), 32'h1);
      chk("wr_c2_err", 32'(wbd_err_o), 32'h0);
      chk("wr_c2_csb", 32'(sram_csb_o), 32'h1);
      wbd_stb_i = 1'b0;
      step();
      chk("wr_c3_ack", 32'(wbd_ack_o), 32'h0);

      xfer(32'h0C00_0010, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("rd1_lat", 32'(lat), 32'(RD_LAT));
      chk("rd1_err", 32'(err), 32'h0);
      chk("rd1_dat", rd, 32'hDEAD_BEEF);
      post("rd1");

      xfer(32'h0C00_0010, 1'b1, 32'h0055_0000, 4'b0100, 1'b0, lat, err, rd);
      chk("bwr_lat", 32'(lat), 32'h2);
      post("bwr");
      xfer(32'h0C00_0010, 1'b0, 32'h0, 4'h0, 1'b0, lat, err, rd);
      chk("bwr_rd_lat", 32'(lat), 32'(RD_LAT));
      chk("bwr_rd_dat", rd, 32'hDE55_BEEF);
      post("bwr_rd");

      xfer(32'h0C00_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, lat, err, rd);
      chk("sel0_lat", 32'(lat), 32'h2);
      chk("sel0_err", 32'(err), 32'h0);
      post("sel0");
      xfer(32'h0C00_0013, 1'b0, 32'h0, 4'h1, 1'b0, lat, err, rd);
      chk("sel0_rd_dat", rd, 32'hDE55_BEEF);
      post("sel0_rd");

      xfer(32'h0C00_07FC, 1'b1, 32'hA5A5_5A5A, 4'hF, 1'b0, lat, err, rd);
      chk("top_wr_err", 32'(err), 32'h0);
      chk("top_mem", mem[511], 32'hA5A5_5A5A);
      post("top_wr");
      xfer(32'h0C00_07FC, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("top_rd_dat", rd, 32'hA5A5_5A5A);
      post("top_rd");

      csb0 = csb_lo;
      xfer(32'h0D00_0000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, lat, err, rd);
      chk("miss_lat", 32'(lat), 32'h1);
      chk("miss_err", 32'(err), 32'h1);
      chk("miss_dat", rd, 32'h0);
      post("miss");
      xfer(32'h0C00_0800, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("miss_edge_lat", 32'(lat), 32'h1);
      chk("miss_edge_err", 32'(err), 32'h1);
      post("miss_edge");
      xfer(32'h0BFF_FFFC, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("miss_low_err", 32'(err), 32'h1);
      post("miss_low");
      chk("miss_csb_idle", 32'(csb_lo - csb0), 32'h0);

      acks0 = ack_cnt;
      xfer(32'h0C00_0020, 1'b1, 32'h1122_3344, 4'hF, 1'b1, lat, err, rd);
      chk("b2b_wr_lat", 32'(lat), 32'h2);
      step();
      chk("b2b_gap_ack", 32'(wbd_ack_o), 32'h0);
      xfer(32'h0C00_0020, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("b2b_rd_lat", 32'(lat), 32'(RD_LAT));
      chk("b2b_rd_dat", rd, 32'h1122_3344);
      post("b2b");
      step();
      chk("b2b_ack_cnt", 32'(ack_cnt - acks0), 32'h2);

      acks0 = ack_cnt;
      wbd_adr_i = 32'h0C00_0010; wbd_we_i = 1'b0; wbd_sel_i = 4'hF; wbd_stb_i = 1'b1;
      step();
      chk("rst_rd_csb_pre", 32'(sram_csb_o), 32'h0);
      #2 wb_rst = 1'b1;
      #1;
      chk("rst_mid_csb", 32'(sram_csb_o), 32'h1);
      chk("rst_mid_ack", 32'(wbd_ack_o), 32'h0);
      wbd_stb_i = 1'b0;
      step();
      wb_rst = 1'b0;
      repeat (5) step();
      chk("rst_no_stale_ack", 32'(ack_cnt - acks0), 32'h0);
      xfer(32'h0C00_0010, 1'b0, 32'h0, 4'hF, 1'b0, lat, err, rd);
      chk("rst_after_lat", 32'(lat), 32'(RD_LAT));
      chk("rst_after_dat", rd, 32'hDE55_BEEF);
      post("rst_after");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
